// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - u4/u5/u64 width typedefs used on the unit's ports
//   - mul_op encodings (bit 3 = 32-bit "W" variant, bit 2 = divide family)
//   - FSM state type, decoded-op struct and small helper functions
package muldiv_unit_pkg;

  typedef logic [3:0]  u4;
  typedef logic [4:0]  u5;
  typedef logic [63:0] u64;

  localparam u4 OP_MUL   = 4'b0000;
  localparam u4 OP_DIV   = 4'b0100;
  localparam u4 OP_DIVU  = 4'b0101;
  localparam u4 OP_REM   = 4'b0110;
  localparam u4 OP_REMU  = 4'b0111;
  localparam u4 OP_MULW  = 4'b1000;
  localparam u4 OP_DIVW  = 4'b1100;
  localparam u4 OP_DIVUW = 4'b1101;
  localparam u4 OP_REMW  = 4'b1110;
  localparam u4 OP_REMUW = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Iteration counter: wide enough to hold 64.
  typedef logic [6:0] cnt_t;
  localparam cnt_t ITER_D = 7'd64;
  localparam cnt_t ITER_W = 7'd32;

  // Most-negative dividend at each operation width (word form is already
  // sign-extended, matching how W operands are presented internally).
  localparam u64 DWORD_MIN = 64'h8000_0000_0000_0000;
  localparam u64 WORD_MIN  = 64'hFFFF_FFFF_8000_0000;

  typedef struct packed {
    logic valid;  // one of the ten defined encodings
    logic word;   // 32-bit variant
    logic div;    // divide/remainder family
    logic sgn;    // operands are signed
    logic rem;    // remainder rather than quotient
  } op_dec_t;

  function automatic op_dec_t decode_op(input u4 op);
    op_dec_t d;
    d.valid = (op[2:0] == 3'b000) | op[2];
    d.word  = op[3];
    d.div   = op[2];
    d.sgn   = ~op[2] | ~op[0];
    d.rem   = op[2] & op[1];
    return d;
  endfunction

  function automatic u64 sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic u64 zext32(input logic [31:0] v);
    return {32'd0, v};
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath shared by multiply and divide.
//   Multiply (radix-2 shift-add): acc += m when q[0]; m <<= 1; q >>= 1.
//   Divide (radix-2 restoring):   shift {acc,q} left one bit, subtract m from
//                                 acc when it fits, quotient bit enters q[0].
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   start           load operands/counter (mode, m, q, cnt)
//   clear           abandon the operation (counter to zero)
//   step            perform one iteration while the counter is non-zero
//   div_mode        mode captured on start
//   load_m, load_q  multiplicand/divisor and multiplier/dividend magnitudes
//   load_cnt        iteration count
//   last            current step is the final one
//   step_lo         product or quotient after the current step
//   step_rem        remainder after the current step
module muldiv_core
  import muldiv_unit_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  input  logic step,
  input  logic div_mode,
  input  u64   load_m,
  input  u64   load_q,
  input  cnt_t load_cnt,
  output logic last,
  output u64   step_lo,
  output u64   step_rem
);

  u64   acc;
  u64   q;
  u64   m;
  cnt_t cnt;
  logic div_q;

  logic [64:0] rem_sh;
  u64          sub;
  logic        ge;
  u64          acc_n;
  u64          q_n;
  u64          m_n;

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (defaults or a complete if/else); a missing branch would infer a latch.
  always_comb begin
    // The partial remainder is below m, so after the shift it fits 65 bits;
    // whenever the subtraction is taken its result fits back into 64.
    rem_sh = {acc, q[63]};
    ge     = (rem_sh >= {1'b0, m});
    sub    = rem_sh[63:0] - m;
    if (div_q) begin
      acc_n = ge ? sub : rem_sh[63:0];
      q_n   = {q[62:0], ge};
      m_n   = m;
    end else begin
      acc_n = q[0] ? (acc + m) : acc;
      q_n   = {1'b0, q[63:1]};
      m_n   = m << 1;
    end
  end

  assign step_lo  = div_q ? q_n : acc_n;
  assign step_rem = acc_n;
  assign last     = (cnt == 7'd1);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      q     <= '0;
      m     <= '0;
      cnt   <= '0;
      div_q <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
    end else if (start) begin
      acc   <= '0;
      q     <= load_q;
      m     <= load_m;
      cnt   <= load_cnt;
      div_q <= div_mode;
    end else if (step && cnt != '0) begin
      acc <= acc_n;
      q   <= q_n;
      m   <= m_n;
      cnt <= cnt - 7'd1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative integer multiply/divide unit (RV64M-style op set).
// Operates on operand magnitudes; the sign is applied once the core finishes.
// Divide-by-zero, signed overflow and undefined op codes resolve at accept
// time and go straight to DONE.
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   in_valid / in_ready     request handshake (ready only in IDLE)
//   mul_op, src_a, src_b    operation and 64-bit operands
//   in_wd                   destination tag carried to out_wd
//   flush                   abort any pending/in-flight operation
//   out_valid / out_ready   result handshake
//   result, out_wd          64-bit result and its tag
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  u4    mul_op,
  input  u64   src_a,
  input  u64   src_b,
  input  u5    in_wd,
  input  logic flush,
  output logic out_valid,
  input  logic out_ready,
  output u64   result,
  output u5    out_wd
);

  state_e state;
  logic   word_q;
  logic   rem_q;
  logic   neg_q;
  u5      wd_q;
  u64     res_q;

  op_dec_t dec;
  u64      a_ext;
  u64      b_ext;
  u64      a_mag;
  u64      b_mag;
  u64      dividend;
  u64      quick_res;
  u64      load_m;
  u64      load_q;
  cnt_t    load_cnt;
  logic    sa;
  logic    sb;
  logic    div_zero;
  logic    overflow;
  logic    quick;
  logic    neg;

  logic accept;
  logic core_start;
  logic core_step;
  logic core_last;
  u64   core_lo;
  u64   core_rem;
  u64   raw;
  u64   signed_raw;
  u64   final_res;

  // Request decode, operand conditioning and early-out detection.
  always_comb begin
    dec = decode_op(mul_op);
    if (dec.word) begin
      a_ext = dec.sgn ? sext32(src_a[31:0]) : zext32(src_a[31:0]);
      b_ext = dec.sgn ? sext32(src_b[31:0]) : zext32(src_b[31:0]);
    end else begin
      a_ext = src_a;
      b_ext = src_b;
    end
    sa    = dec.sgn & a_ext[63];
    sb    = dec.sgn & b_ext[63];
    a_mag = sa ? (64'd0 - a_ext) : a_ext;
    b_mag = sb ? (64'd0 - b_ext) : b_ext;

    // W results are always sign-extended from bit 31, even for unsigned ops.
    dividend = dec.word ? sext32(a_ext[31:0]) : a_ext;
    div_zero = dec.div & (b_ext == '0);
    overflow = dec.div & dec.sgn & (b_ext == '1) &
               (a_ext == (dec.word ? WORD_MIN : DWORD_MIN));
    quick    = ~dec.valid | div_zero | overflow;

    quick_res = '0;
    if (dec.valid) begin
      if (div_zero) begin
        quick_res = dec.rem ? dividend : '1;
      end else if (overflow) begin
        quick_res = dec.rem ? '0 : dividend;
      end
    end

    // Remainder takes the dividend's sign; product/quotient the xor.
    neg = dec.rem ? sa : (sa ^ sb);

    // Divide: dividend sits in q's top bits so its MSB shifts out first;
    // a W dividend is pre-shifted so 32 steps leave the quotient in q[31:0].
    load_m   = dec.div ? b_mag : a_mag;
    load_q   = dec.div ? (dec.word ? (a_mag << 32) : a_mag) : b_mag;
    load_cnt = dec.word ? ITER_W : ITER_D;
  end

  assign in_ready   = (state == ST_IDLE);
  assign out_valid  = (state == ST_DONE);
  assign accept     = in_valid & in_ready & ~flush;
  assign core_start = accept & ~quick;
  assign core_step  = (state == ST_BUSY) & ~flush;
  assign result     = res_q;
  assign out_wd     = wd_q;

  // Sign fix-up of the core's final step, captured on the last edge.
  always_comb begin
    raw        = rem_q ? core_rem : core_lo;
    signed_raw = neg_q ? (64'd0 - raw) : raw;
    final_res  = word_q ? sext32(signed_raw[31:0]) : signed_raw;
  end

  muldiv_core u_core (
    .clk      (clk),
    .reset    (reset),
    .start    (core_start),
    .clear    (flush),
    .step     (core_step),
    .div_mode (dec.div),
    .load_m   (load_m),
    .load_q   (load_q),
    .load_cnt (load_cnt),
    .last     (core_last),
    .step_lo  (core_lo),
    .step_rem (core_rem)
  );

  // Flush outranks both a new request and the output handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      word_q <= 1'b0;
      rem_q  <= 1'b0;
      neg_q  <= 1'b0;
      wd_q   <= '0;
      res_q  <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            word_q <= dec.word;
            rem_q  <= dec.rem;
            neg_q  <= neg;
            wd_q   <= in_wd;
            if (quick) begin
              res_q <= quick_res;
              state <= ST_DONE;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (core_last) begin
            res_q <= final_res;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = asserted).
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  unit can accept a request; high only in IDLE.
REQ-006 mul_op  input  u4  op code: 0000 mul, 0100 div, 0101 divu, 0110 rem, 0111 remu, 1000 mulw, 1100 divw, 1101 divuw, 1110 remw, 1111 remuw.
REQ-007 src_a, src_b  input  u64 each  operands (rs1, rs2 values).
REQ-008 in_wd  input  u5  destination register tag.
REQ-009 flush  input  1  abort any in-flight or pending operation.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  u64  final 64-bit value.
REQ-013 out_wd  output  u5  tag captured with the request.

Function
REQ-014 Request accept: in_valid & in_ready & !flush at a rising edge; operands, mul_op and in_wd are latched in that cycle (T).
REQ-015 States: IDLE, BUSY, DONE; IDLE->BUSY on accept; BUSY->DONE when iteration counter expires; DONE->IDLE on out_valid & out_ready.
REQ-016 Multiply: radix-2 iterative shift-add on operand magnitudes, sign fixed at the end; low 64 bits of product returned for mul.
REQ-017 Divide/remainder: radix-2 restoring division on magnitudes; quotient sign = sign(a) xor sign(b); remainder sign = sign(a); unsigned variants skip sign handling.
REQ-018 Iterations: 64 for 64-bit ops (out_valid first high at T+65), 32 for W ops (out_valid at T+33).
REQ-019 W ops: operands taken from bits [31:0], sign-extended (signed ops) or zero-extended (divuw/remuw); 32-bit result sign-extended to 64 bits (including divuw/remuw).
REQ-020 Divide by zero: quotient = all ones (at operation width), remainder = dividend; resolved without iteration, out_valid at T+1.
REQ-021 Signed overflow (most-negative / -1 at operation width): quotient = dividend, remainder = 0; out_valid at T+1.
REQ-022 Undefined mul_op codes: result = 0, out_valid at T+1.
REQ-023 In DONE, result and out_wd SHALL be held stable while out_valid & !out_ready; in_ready stays low.
REQ-024 After the output handshake in cycle D, in_ready is high in D+1; no same-cycle re-accept.
REQ-025 Flush in BUSY or DONE: return to IDLE next cycle, out_valid deasserted next cycle, result discarded; flush takes priority over in_valid and out_ready in the same cycle.
REQ-026 result and out_wd are don't-care while out_valid is low but SHALL be driven (no X).

Reset
REQ-027 On reset assertion (asynchronous): state = IDLE, counter = 0, out_valid = 0, result = 0, out_wd = 0; in_ready = 1 once reset deasserts.
REQ-028 Reset mid-operation SHALL abandon the operation with no output handshake.

Structure
REQ-029 mul_op encoding constants and the state enum type SHALL live in the shared common package, alongside u4/u5/u64.
REQ-030 One sub-module, muldiv_core (datapath: shift registers, adder/subtractor, counter), SHALL be instantiated; FSM and handshake remain in muldiv_unit.

Verification
REQ-031 mul src_a=7, src_b=0xFFFF_FFFF_FFFF_FFFD (-3), out_ready=1 -> result 0xFFFF_FFFF_FFFF_FFEB, out_valid at T+65 for exactly one cycle.
REQ-032 mulw src_a=0x7FFF_FFFF, src_b=2 -> result 0xFFFF_FFFF_FFFF_FFFE at T+33.
REQ-033 div src_a=0x8000_0000_0000_0000, src_b=-1 -> result 0x8000_0000_0000_0000 at T+1; rem same operands -> 0 at T+1.
REQ-034 divu 100/0 -> 0xFFFF_FFFF_FFFF_FFFF at T+1; remu 100/0 -> 100; rem -7/2 -> 0xFFFF_FFFF_FFFF_FFFF (-1); div -7/2 -> -3.
REQ-035 div 100/7, out_ready low 5 cycles after out_valid -> result 14 and out_wd held stable, in_ready low; after handshake in_ready high next cycle.
REQ-036 Flush at T+10 of a div (and separately reset at T+10) -> out_valid never asserts, in_ready high the following cycle, next request completes correctly.
